// File: rtl/pio_edge_pkg.sv
// Shared definitions for the PIO edge-capture block: register map, event counter
// width and the supported parameter ranges.
package pio_edge_pkg;

    typedef enum logic [2:0] {
        REG_DATA        = 3'd0,
        REG_RISE_EN     = 3'd1,
        REG_IRQ_MASK    = 3'd2,
        REG_EDGE_CAP    = 3'd3,
        REG_FALL_EN     = 3'd4,
        REG_FILTER_LEN  = 3'd5,
        REG_EVENT_COUNT = 3'd6,
        REG_RSVD        = 3'd7
    } reg_addr_e;

    localparam int EVENT_COUNT_W   = 16;

    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 32;
    localparam int SYNC_MIN        = 2;
    localparam int SYNC_MAX        = 4;
    localparam int FILTER_BITS_MIN = 1;
    localparam int FILTER_BITS_MAX = 8;

    // Saturating increment so the event counter sticks at all-ones.
    function automatic logic [EVENT_COUNT_W-1:0] sat_inc(input logic [EVENT_COUNT_W-1:0] v);
        return (v == '1) ? v : v + EVENT_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/pio_edge_capture_if.sv
// Memory-mapped slave bus for the PIO edge-capture block.
interface pio_edge_capture_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_glitch_filter.sv
// One channel of glitch filtering: a new level is accepted only after it has
// disagreed with the filtered value for filter_len+1 consecutive cycles.
module pio_glitch_filter #(
    parameter int FILTER_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_in,
    input  logic [FILTER_BITS-1:0] filter_len,
    output logic                   filt,
    output logic                   rise,
    output logic                   fall
);

    logic [FILTER_BITS-1:0] count_q, count_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;

    // Using >= lets a shortened filter_len release a channel that is already past it.
    always_comb begin
        count_d     = count_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        if (sync_in == filt_q) begin
            count_d = '0;
        end else if (count_q >= filter_len) begin
            filt_d  = sync_in;
            count_d = '0;
        end else begin
            count_d = count_q + FILTER_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
        end
    end

    assign filt = filt_q;
    assign rise = filt_q & ~filt_prev_q;
    assign fall = ~filt_q & filt_prev_q;

endmodule

// File: rtl/pio_edge_capture.sv
// Parallel input port with synchronizers, per-channel glitch filters, enabled
// rise/fall edge capture, a saturating event counter and a masked level interrupt.
module pio_edge_capture
    import pio_edge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_edge_capture_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0]         sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]         sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]         filt, rise, fall, edge_event;

    logic [WIDTH-1:0]         rise_en_q, rise_en_d;
    logic [WIDTH-1:0]         fall_en_q, fall_en_d;
    logic [WIDTH-1:0]         irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]         edge_cap_q, edge_cap_d;
    logic [FILTER_BITS-1:0]   filter_len_q, filter_len_d;
    logic [EVENT_COUNT_W-1:0] event_count_q, event_count_d;
    logic [31:0]              readdata_q, readdata_d;

    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic [WIDTH-1:0]         w1c_mask;
    reg_addr_e                addr;
    logic                     unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wr_data      = bus.writedata[WIDTH-1:0];
    assign addr         = reg_addr_e'(bus.address);
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        pio_glitch_filter #(
            .FILTER_BITS (FILTER_BITS)
        ) u_filter (
            .clk        (clk),
            .reset_n    (reset_n),
            .sync_in    (sync_q[SYNC_STAGES-1][gi]),
            .filter_len (filter_len_q),
            .filt       (filt[gi]),
            .rise       (rise[gi]),
            .fall       (fall[gi])
        );
        assign edge_event[gi] = (rise[gi] & rise_en_q[gi]) | (fall[gi] & fall_en_q[gi]);
    end

    always_comb begin
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_mask_d   = irq_mask_q;
        filter_len_d = filter_len_q;
        w1c_mask     = '0;
        readdata_d   = '0;

        case (addr)
            REG_DATA:        readdata_d = 32'(filt);
            REG_RISE_EN:     readdata_d = 32'(rise_en_q);
            REG_IRQ_MASK:    readdata_d = 32'(irq_mask_q);
            REG_EDGE_CAP:    readdata_d = 32'(edge_cap_q);
            REG_FALL_EN:     readdata_d = 32'(fall_en_q);
            REG_FILTER_LEN:  readdata_d = 32'(filter_len_q);
            REG_EVENT_COUNT: readdata_d = 32'(event_count_q);
            default:         readdata_d = '0;
        endcase

        if (wr_en) begin
            case (addr)
                REG_RISE_EN:    rise_en_d    = wr_data;
                REG_IRQ_MASK:   irq_mask_d   = wr_data;
                REG_EDGE_CAP:   w1c_mask     = wr_data;
                REG_FALL_EN:    fall_en_d    = wr_data;
                REG_FILTER_LEN: filter_len_d = bus.writedata[FILTER_BITS-1:0];
                default:        ;
            endcase
        end

        // A fresh event wins over a clear landing in the same cycle.
        edge_cap_d = (edge_cap_q & ~w1c_mask) | edge_event;

        if (wr_en && addr == REG_EVENT_COUNT) begin
            event_count_d = (|edge_event) ? EVENT_COUNT_W'(1) : '0;
        end else if (|edge_event) begin
            event_count_d = sat_inc(event_count_q);
        end else begin
            event_count_d = event_count_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            irq_mask_q    <= '0;
            edge_cap_q    <= '0;
            filter_len_q  <= '0;
            event_count_q <= '0;
            readdata_q    <= '0;
        end else begin
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            irq_mask_q    <= irq_mask_d;
            edge_cap_q    <= edge_cap_d;
            filter_len_q  <= filter_len_d;
            event_count_q <= event_count_d;
            readdata_q    <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_capture.sv
// Directed bench for pio_edge_capture: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_pio_edge_capture;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int FB = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = 3'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pio_edge_capture_if bus_if ();
    assign bus_if.address    = address;
    assign bus_if.chipselect = chipselect;
    assign bus_if.write_n    = write_n;
    assign bus_if.writedata  = writedata;
    assign readdata          = bus_if.readdata;

    pio_edge_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .FILTER_BITS (FB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    // ---------------- behavioural model ----------------
    bit [W-1:0]  m_pipe [S];
    int          m_run  [W];
    bit [W-1:0]  m_filt, m_prev, m_rise_en, m_fall_en, m_mask, m_cap;
    bit [W-1:0]  m_ev, m_sync, m_nf, m_cap_new;
    int          m_flen, m_cnt;
    bit [31:0]   m_rd;
    bit          m_irq, m_wr;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int s = 0; s < S; s++) m_pipe[s] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_filt = '0; m_prev = '0; m_rise_en = '0; m_fall_en = '0;
            m_mask = '0; m_cap = '0; m_flen = 0; m_cnt = 0; m_rd = '0; m_irq = 1'b0;
        end else begin
            m_sync = m_pipe[S-1];
            // A channel reports an event when its filtered level changed on the
            // previous clock and that direction is enabled.
            m_ev = '0;
            for (int i = 0; i < W; i++)
                if (m_filt[i] != m_prev[i])
                    m_ev[i] = m_filt[i] ? m_rise_en[i] : m_fall_en[i];
            case (int'(address))
                0: m_rd = 32'(m_filt);
                1: m_rd = 32'(m_rise_en);
                2: m_rd = 32'(m_mask);
                3: m_rd = 32'(m_cap);
                4: m_rd = 32'(m_fall_en);
                5: m_rd = 32'(m_flen);
                6: m_rd = 32'(m_cnt);
                default: m_rd = '0;
            endcase
            m_wr = chipselect && !write_n;
            m_cap_new = m_cap;
            if (m_wr && address == 3'd3) m_cap_new = m_cap_new & ~writedata[W-1:0];
            m_cap_new = m_cap_new | m_ev;
            if (m_wr && address == 3'd6)  m_cnt = (m_ev != 0) ? 1 : 0;
            else if (m_ev != 0)           m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            // A new level is accepted after flen+1 consecutive disagreeing cycles.
            m_nf = m_filt;
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] == m_filt[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > m_flen) begin
                        m_nf[i]  = m_sync[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_prev = m_filt;
            m_filt = m_nf;
            if (m_wr) begin
                case (int'(address))
                    1: m_rise_en = writedata[W-1:0];
                    2: m_mask    = writedata[W-1:0];
                    4: m_fall_en = writedata[W-1:0];
                    5: m_flen    = int'(writedata[FB-1:0]);
                    default: ;
                endcase
            end
            for (int s = S-1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = in_port;
            m_cap = m_cap_new;
            m_irq = |(m_cap & m_mask);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en && reset_n) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        $display("WR  addr=%0d data=%h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
        $display("RD  addr=%0d data=%h", a, d);
    endtask

    logic [31:0] v;

    initial begin
        tick(2);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick(1);
        chk_en = 1'b1;
        rd(3'd1, v); chk("reset_rise_en", v, 32'h0);
        rd(3'd5, v); chk("reset_filter_len", v, 32'h0);

        // Rise on channel 0, no filtering: capture lands 4 clocks after the input change.
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h01);
        address = 3'd3;
        in_port[0] = 1'b1;
        tick(3); chk("latency_irq_3clk", 32'(irq), 32'h0);
        tick(1); chk("latency_irq_4clk", 32'(irq), 32'h1);
        tick(1); chk("edge_cap_bit0", readdata, 32'h01);
        rd(3'd6, v); chk("event_count_one", v, 32'h1);
        rd(3'd0, v); chk("data_bit0", v, 32'h01);
        wr(3'd3, 32'h01);
        chk("w1c_irq_clear", 32'(irq), 32'h0);

        // Glitch filter: length 3 rejects a 2-cycle pulse, accepts a 6-cycle one.
        wr(3'd4, 32'h80);
        wr(3'd5, 32'h3);
        in_port[7] = 1'b1; tick(10);
        in_port[7] = 1'b0; tick(2);
        in_port[7] = 1'b1; tick(12);
        rd(3'd3, v); chk("short_pulse_rejected", v, 32'h00);
        in_port[7] = 1'b0; tick(6);
        in_port[7] = 1'b1; tick(12);
        rd(3'd3, v); chk("long_pulse_captured", v, 32'h80);
        rd(3'd0, v); chk("data_after_pulse", v, 32'h81);
        wr(3'd3, 32'h80);

        // Interrupt masking on channel 2.
        wr(3'd5, 32'h0);
        wr(3'd2, 32'h04);
        wr(3'd1, 32'h05);
        in_port[2] = 1'b1; tick(6);
        chk("irq_bit2_set", 32'(irq), 32'h1);
        rd(3'd3, v); chk("edge_cap_bit2", v, 32'h04);
        wr(3'd3, 32'h04);
        chk("irq_bit2_cleared", 32'(irq), 32'h0);

        // Clear racing a new event on the same bit: the bit must survive.
        wr(3'd4, 32'h84);
        in_port[2] = 1'b0; tick(6);
        chk("irq_fall_bit2", 32'(irq), 32'h1);
        in_port[2] = 1'b1; tick(3);
        wr(3'd3, 32'h04);
        chk("w1c_vs_event_kept", 32'(irq), 32'h1);
        tick(1);
        wr(3'd3, 32'h04);
        chk("w1c_alone_clears", 32'(irq), 32'h0);

        // Saturate the event counter, then clear it while events keep arriving.
        wr(3'd1, 32'h01);
        wr(3'd4, 32'h01);
        wr(3'd2, 32'h00);
        wr(3'd6, 32'h00);
        address = 3'd6;
        for (int i = 0; i < 65545; i++) begin
            in_port[0] = ~in_port[0];
            if (i == 65543) begin chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0; end
            if (i == 65544) begin chipselect = 1'b0; write_n = 1'b1; end
            @(negedge clk);
            if (i == 65542) chk("event_count_saturated", readdata, 32'h0000FFFF);
            if (i == 65544) chk("event_count_clear_with_event", readdata, 32'h1);
        end
        $display("TOGGLE channel0 x65545, event count cleared under load");
        tick(5);

        // Reset in the middle of a filter count with every input high.
        wr(3'd1, 32'h00);
        wr(3'd4, 32'h00);
        in_port = '0; tick(6);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'hFF);
        wr(3'd5, 32'h5);
        in_port = '1; tick(4);
        chk("pre_reset_no_capture", 32'(irq), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 32'h0);
        chk("async_reset_irq", 32'(irq), 32'h0);
        tick(2);
        chk("held_reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        tick(12);
        rd(3'd3, v); chk("post_reset_no_capture", v, 32'h00);
        chk("post_reset_irq", 32'(irq), 32'h0);
        rd(3'd0, v); chk("post_reset_data", v, 32'hFF);
        rd(3'd6, v); chk("post_reset_event_count", v, 32'h0);
        rd(3'd1, v); chk("post_reset_rise_en", v, 32'h0);
        rd(3'd7, v); chk("reserved_reads_zero", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_edge_capture.md
PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

Interface
REQ-001 SHALL have parameter WIDTH, 8, number of input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, 2, synchronizer depth (2..4).
REQ-003 SHALL have parameter FILTER_BITS, 4, glitch-filter counter width (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port address  input  3  register word select.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-011 SHALL have port readdata  output  32  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 Each in_port bit SHALL pass through a SYNC_STAGES-deep flop chain; last stage = sync[i].
REQ-014 Per channel: sync[i]==filt[i] clears counter; otherwise counter increments, and when counter==FILTER_LEN, filt[i]<=sync[i] and counter clears.
REQ-015 FILTER_LEN=0 SHALL make filt follow sync with one cycle delay; counter SHALL never wrap.
REQ-016 filt_d SHALL register filt; rise=filt&~filt_d, fall=~filt&filt_d.
REQ-017 event[i]=(rise[i]&RISE_EN[i])|(fall[i]&FALL_EN[i]); event SHALL set EDGE_CAPTURE[i] on the next edge.
REQ-018 Latency, FILTER_LEN=0: in_port change to EDGE_CAPTURE set = SYNC_STAGES+2 cycles.
REQ-019 Register map: 0 DATA=filt (RO); 1 RISE_EN (RW); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (write-1-to-clear per bit); 4 FALL_EN (RW); 5 FILTER_LEN (RW, low FILTER_BITS); 6 EVENT_COUNT (RO, any write clears); 7 reads 0.
REQ-020 Writes occur when chipselect & ~write_n; RW registers take writedata[WIDTH-1:0]; upper bits ignored.
REQ-021 readdata SHALL register the addressed value every cycle, zero-extended; read latency 1 cycle; unused bits 0.
REQ-022 Simultaneous W1C and new event on same bit: bit SHALL remain set.
REQ-023 EVENT_COUNT (16 bit) SHALL increment by 1 per cycle with any event bit set, saturating at 0xFFFF.
REQ-024 Simultaneous EVENT_COUNT clear and event: count SHALL become 1.
REQ-025 irq SHALL be combinational |(EDGE_CAPTURE & IRQ_MASK).
REQ-026 FILTER_LEN write mid-count SHALL take effect next cycle; counter>=new FILTER_LEN SHALL update filt.

Reset
REQ-027 reset_n low SHALL asynchronously clear sync chain, filt, filt_d, counters, all registers, EVENT_COUNT, readdata; irq=0.
REQ-028 After reset RISE_EN=FALL_EN=0, so inputs high at release SHALL NOT capture.
REQ-029 Reset mid-filter-count SHALL discard pending transitions.

Structure
REQ-030 Package pio_edge_pkg SHALL hold register address constants, EVENT_COUNT width, parameter limits.
REQ-031 Sub-module pio_glitch_filter (one channel: counter, filt, filt_d, rise/fall) SHALL be instantiated WIDTH times.

Verification
REQ-032 WIDTH=8, RISE_EN=0x01, FILTER_LEN=0, in_port[0] 0->1 -> EDGE_CAPTURE=0x01 after 4 cycles, EVENT_COUNT=1.
REQ-033 FALL_EN=0x80, FILTER_LEN=3, 2-cycle low pulse on in_port[7] -> no capture; 6-cycle pulse -> EDGE_CAPTURE[7]=1.
REQ-034 IRQ_MASK=0x04, capture bit 2 -> irq=1; write 0x04 to addr 3 -> irq=0 next cycle.
REQ-035 W1C addr 3 in same cycle as new bit-2 event -> EDGE_CAPTURE[2] stays 1.
REQ-036 Force 0x10000 events -> EVENT_COUNT=0xFFFF; write addr 6 with concurrent event -> 1.
REQ-037 Assert reset_n mid-filter-count with in_port=0xFF -> all reads 0, irq=0, no capture after release.
